if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the five-stage MIPS pipeline. Holds the PC and a word-addressed instruction memory, and registers the fetched word into the IF/ID pipeline register. It directly feeds the ID-stage register file: the `instruction` output drives rs/rt field decode and sign-extension, and `pc_plus4` travels on toward branch-target computation. The stage supports stall (load-use hazard), flush (taken branch/jump) and a memory load port used by benches and boot.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset.
IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
IMEM_AW, 8, word-address width; must equal log2(IMEM_DEPTH).

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold PC and IF/ID contents (from hazard unit).
flush  input  1  squash IF/ID contents (from branch/jump resolution).
branch_taken  input  1  redirect PC to branch_target.
branch_target  input  32  redirect address; bits [1:0] are ignored.
load_en  input  1  write enable for instruction memory.
load_addr  input  IMEM_AW  word address for the load write.
load_data  input  32  word written on load.
pc  output  32  current fetch PC (register).
instruction  output  32  IF/ID instruction; 32'h0 (sll $0 NOP) when invalid.
pc_plus4  output  32  IF/ID copy of fetch PC + 4.
if_valid  output  1  IF/ID holds a real, unsquashed instruction.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC; instruction=0; pc_plus4=0; if_valid=0. Instruction memory contents are not cleared. rst has priority over every other input. Reset asserted mid-stream discards the in-flight IF/ID word.
- Fetch read: combinational, word index = pc[IMEM_AW+1:2]. If pc[31:IMEM_AW+2] is nonzero (out of range), the fetched word is 32'h0.
- Normal cycle (no rst, stall, flush or branch_taken): instruction<=fetched word; pc_plus4<=pc+4; if_valid<=1; pc<=pc+4. Latency is one cycle from PC to IF/ID.
- PC update priority:
  - rst: RESET_PC.
  - branch_taken: {branch_target[31:2],2'b00}. This applies even during stall, so a resolved branch is never lost.
  - stall: hold.
  - otherwise: pc+4.
- IF/ID update priority: rst > flush > stall > normal.
  - flush: instruction<=0, pc_plus4<=0, if_valid<=0.
  - stall: hold all three.
- Simultaneous flush and stall: flush wins for IF/ID; PC follows the PC rule above.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0. There is no trap.
- Load port: on an edge with load_en=1, imem[load_addr]<=load_data. A read of the same address in the same cycle returns the old word; the new word is visible from the next cycle. Loads are allowed during rst and normal operation.
- No state machine beyond the PC and IF/ID registers. All outputs are registered; nothing depends combinationally on inputs.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR = 32'h0.
  - WORD_BYTES = 4.
  - The RESET_PC default.
  - Instruction field-position constants (rs [25:21], rt [20:16], imm [15:0]), shared with the ID-stage register file.
- One natural sub-module, if_imem: a single-write-port, asynchronous-read word memory (IMEM_DEPTH x 32) with the out-of-range-returns-zero rule.
- The PC and IF/ID registers remain in if_fetch_stage.

Test Plan:
- Sequential fetch: load imem[0..3]=32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'hAC0A_0000; release rst. Required response: instruction matches each word in order on cycles 1–4; pc_plus4=4,8,12,16; if_valid=1.
- Stall: assert stall for 2 cycles while IF/ID holds word 1 (pc_plus4=8). Required response: instruction and pc_plus4 unchanged; pc holds 8; on release, word 2 follows with pc_plus4=12.
- Branch with flush: at pc=8 assert branch_taken, flush, branch_target=32'h0000_0002 for one cycle. Required response: next IF/ID is instruction=0, if_valid=0; pc=0; the following cycle gives imem[0] with pc_plus4=4.
- Branch during stall: assert stall and branch_taken with target 32'h10 together. Required response: pc=32'h10; IF/ID held; after stall drops, instruction=imem[4].
- Out-of-range and wrap: branch to 32'h0000_0400 (index 256). Required response: instruction=0 with if_valid=1. Separately, force pc to 32'hFFFF_FFFC; the next pc is 0.
- Reset mid-run and load collision: assert rst while if_valid=1. Required response: next edge gives pc=0, instruction=0, if_valid=0. In a separate run, write imem[2] in the same cycle pc=8: the old word is fetched, and a refetch returns the new word.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: NOP encoding, word size, reset PC and
// instruction field positions used by both IF and ID stages.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    function automatic logic [4:0] instr_rs(input logic [31:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] instr_rt(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [15:0] instr_imm(input logic [31:0] instr);
        return instr[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Control, load-port and IF/ID signals of the fetch stage; the stage is the
// slave, the hazard/branch logic (or a bench) is the master.
interface if_fetch_stage_if #(
    parameter int IMEM_AW = 8
);
    logic                stall;
    logic                flush;
    logic                branch_taken;
    logic [31:0]         branch_target;
    logic                load_en;
    logic [IMEM_AW-1:0]  load_addr;
    logic [31:0]         load_data;
    logic [31:0]         pc;
    logic [31:0]         instruction;
    logic [31:0]         pc_plus4;
    logic                if_valid;

    modport master (
        output stall, flush, branch_taken, branch_target,
        output load_en, load_addr, load_data,
        input  pc, instruction, pc_plus4, if_valid
    );

    modport slave (
        input  stall, flush, branch_taken, branch_target,
        input  load_en, load_addr, load_data,
        output pc, instruction, pc_plus4, if_valid
    );
endinterface

// File: rtl/if_fetch_stage_imem.sv
// Word-addressed instruction memory: one synchronous write port, asynchronous
// read; addresses beyond the array read as NOP.
module if_imem
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int IMEM_AW    = 8
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [IMEM_AW-1:0] wr_addr,
    input  logic [31:0]        wr_data,
    input  logic [29:0]        rd_word_addr,
    output logic [31:0]        rd_data
);

    logic [31:0] mem_r [IMEM_DEPTH];
    logic        oor_s;

    assign oor_s = |rd_word_addr[29:IMEM_AW];

    // Load-port write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read with out-of-range squash to NOP.
    always_comb begin
        rd_data = NOP_INSTR;
        if (oor_s) begin
            rd_data = NOP_INSTR;
        end else begin
            rd_data = mem_r[rd_word_addr[IMEM_AW-1:0]];
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, instruction memory and the IF/ID
// pipeline register, with stall, flush and branch redirect.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_DEPTH = 256,
    parameter int          IMEM_AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_stage_if.slave  bus
);

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_inc_s;
    logic [31:0] fetch_word_s;
    logic [31:0] instr_r;
    logic [31:0] pc_plus4_r;
    logic        valid_r;

    if_imem #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .IMEM_AW    (IMEM_AW)
    ) u_imem (
        .clk          (clk),
        .wr_en        (bus.load_en),
        .wr_addr      (bus.load_addr),
        .wr_data      (bus.load_data),
        .rd_word_addr (pc_r[31:2]),
        .rd_data      (fetch_word_s)
    );

    assign pc_inc_s = pc_r + WORD_BYTES;

    // Next PC: a resolved branch overrides a stall so it is never dropped.
    always_comb begin
        pc_next_s = pc_r;
        if (bus.branch_taken) begin
            pc_next_s = {bus.branch_target[31:2], 2'b00};
        end else if (bus.stall) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_inc_s;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // IF/ID register: flush beats stall so a squashed slot cannot be held.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r    <= NOP_INSTR;
            pc_plus4_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else if (bus.flush) begin
            instr_r    <= NOP_INSTR;
            pc_plus4_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else if (bus.stall) begin
            instr_r    <= instr_r;
            pc_plus4_r <= pc_plus4_r;
            valid_r    <= valid_r;
        end else begin
            instr_r    <= fetch_word_s;
            pc_plus4_r <= pc_inc_s;
            valid_r    <= 1'b1;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.instruction = instr_r;
    assign bus.pc_plus4    = pc_plus4_r;
    assign bus.if_valid    = valid_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: each task drives one scenario and checks
// the packed {instruction, pc_plus4, if_valid, pc} tuple after each edge.
module tb_if_fetch_stage;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] words [6];
    logic [96:0] obs_v;
    logic [96:0] exp_v;

    if_fetch_stage_if #(.IMEM_AW(8)) bus ();

    if_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (256),
        .IMEM_AW    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [96:0] pack(input logic [31:0] i, input logic [31:0] p4,
                                         input logic v, input logic [31:0] pc);
        return {i, p4, v, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        obs_v = {bus.instruction, bus.pc_plus4, bus.if_valid, bus.pc};
    endtask

    task automatic idle_inputs();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0; bus.load_en = 1'b0;
        bus.load_addr = 8'h00; bus.load_data = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.load_en = 1'b1; bus.load_addr = 8'(i); bus.load_data = words[i];
            tick();
        end
        bus.load_en = 1'b0;
        exp_v = pack(32'h0, 32'h0, 1'b0, 32'h0);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL reset_state got %h want %h", obs_v, exp_v); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_v = pack(words[k], 32'(4*(k+1)), 1'b1, 32'(4*(k+1)));
            n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL seq_fetch%0d got %h want %h", k, obs_v, exp_v); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        bus.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_v = pack(words[1], 32'd8, 1'b1, 32'd8);
            n_vec++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL stall_hold%0d got %h want %h", k, obs_v, exp_v); end
        end
        bus.stall = 1'b0;
        tick();
        exp_v = pack(words[2], 32'd12, 1'b1, 32'd12);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL stall_release got %h want %h", obs_v, exp_v); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        tick(); tick();
        bus.branch_taken = 1'b1; bus.flush = 1'b1; bus.branch_target = 32'h0000_0002;
        tick();
        idle_inputs();
        exp_v = pack(32'h0, 32'h0, 1'b0, 32'h0);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL branch_flush got %h want %h", obs_v, exp_v); end
        tick();
        exp_v = pack(words[0], 32'd4, 1'b1, 32'd4);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL branch_refetch got %h want %h", obs_v, exp_v); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        tick(); tick();
        bus.flush = 1'b1; bus.stall = 1'b1;
        tick();
        idle_inputs();
        exp_v = pack(32'h0, 32'h0, 1'b0, 32'd8);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL flush_stall got %h want %h", obs_v, exp_v); end
        tick();
        exp_v = pack(words[2], 32'd12, 1'b1, 32'd12);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL flush_stall_release got %h want %h", obs_v, exp_v); end
    endtask

    task automatic test_branch_stall();
        do_reset();
        tick(); tick();
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0010;
        tick();
        idle_inputs();
        exp_v = pack(words[1], 32'd8, 1'b1, 32'h10);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL branch_in_stall got %h want %h", obs_v, exp_v); end
        tick();
        exp_v = pack(words[4], 32'h14, 1'b1, 32'h14);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL branch_stall_fetch got %h want %h", obs_v, exp_v); end
    endtask

    task automatic test_oor_wrap();
        do_reset();
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0400;
        tick();
        idle_inputs();
        tick();
        exp_v = pack(32'h0, 32'h404, 1'b1, 32'h404);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL oor_fetch got %h want %h", obs_v, exp_v); end
        bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        exp_v = pack(32'h0, 32'h408, 1'b1, 32'hFFFF_FFFC);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL force_top_pc got %h want %h", obs_v, exp_v); end
        tick();
        exp_v = pack(32'h0, 32'h0, 1'b1, 32'h0);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL pc_wrap got %h want %h", obs_v, exp_v); end
        tick();
        exp_v = pack(words[0], 32'd4, 1'b1, 32'd4);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL post_wrap_fetch got %h want %h", obs_v, exp_v); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        tick(); tick();
        n_vec++;
        if (bus.if_valid !== 1'b1) begin n_err++; $display("FAIL midrun_valid got %b want 1", bus.if_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_v = pack(32'h0, 32'h0, 1'b0, 32'h0);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL midrun_reset got %h want %h", obs_v, exp_v); end
    endtask

    task automatic test_load_collision();
        do_reset();
        tick(); tick();
        bus.load_en = 1'b1; bus.load_addr = 8'd2; bus.load_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        exp_v = pack(words[2], 32'd12, 1'b1, 32'd12);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL load_old_word got %h want %h", obs_v, exp_v); end
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0008;
        tick();
        idle_inputs();
        tick();
        exp_v = pack(32'hDEAD_BEEF, 32'd12, 1'b1, 32'd12);
        n_vec++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL load_new_word got %h want %h", obs_v, exp_v); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        words[0] = 32'h2008_0005;
        words[1] = 32'h2009_0003;
        words[2] = 32'h0109_5020;
        words[3] = 32'hAC0A_0000;
        words[4] = 32'h1234_5678;
        words[5] = 32'h8765_4321;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_branch_flush();
        test_flush_stall();
        test_branch_stall();
        test_oor_wrap();
        test_reset_midrun();
        test_load_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
